// File: rtl/led_frame_sched_pkg.sv
// Shared types and constants for the WS2812B frame scheduler.
// Register offsets are the GPMC addresses that feed hblank_req and the pixel FIFO.
package led_frame_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DRAIN,
        ST_LATCH
    } state_t;

    localparam int          LATCH_CYCLES_DEF = 5500;
    localparam int          BYTES_PER_PIXEL  = 3;
    localparam logic [15:0] REG_HBLANK       = 16'h0014;
    localparam logic [15:0] REG_PIX_FIFO     = 16'h1000;

    // 16-bit FIFO words needed to fill one pixel on every string.
    function automatic int words_per_set(input int n_strings);
        return BYTES_PER_PIXEL * n_strings / 2;
    endfunction

endpackage

// File: rtl/led_pixel_unpack.sv
// Splits 16-bit FIFO words into bytes and steers each byte into its string's pixel register.
// Stream byte k lands in string k/3 at byte position k%3, so b0 ends up in the low byte of each pixel.
module led_pixel_unpack
    import led_frame_sched_pkg::*;
#(
    parameter int N_STRINGS = 2,
    parameter int WIDX_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [WIDX_W-1:0]         word_idx,
    input  logic [15:0]               word,
    output logic [24*N_STRINGS-1:0]   pix_data
);

    localparam int N_BYTES = BYTES_PER_PIXEL * N_STRINGS;

    logic [7:0] pix_byte [N_BYTES];

    // NOTE: these are plain registers rather than a RAM, so they take the reset and pix_data reads 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_BYTES; k++) begin
                pix_byte[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < N_BYTES; k++) begin
                if (word_idx == WIDX_W'(k / 2)) begin
                    pix_byte[k] <= (k % 2 != 0) ? word[15:8] : word[7:0];
                end
            end
        end
    end

    always_comb begin
        pix_data = '0;
        for (int k = 0; k < N_BYTES; k++) begin
            pix_data[(k / BYTES_PER_PIXEL) * 24 + (k % BYTES_PER_PIXEL) * 8 +: 8] = pix_byte[k];
        end
    end

endmodule

// File: rtl/led_frame_sched.sv
// Frame scheduler: pulls pixel words from the FIFO, hands one pixel per string to the
// serializers, then forces the reset/latch gap on the lines after every frame or hblank request.
module led_frame_sched
    import led_frame_sched_pkg::*;
#(
    parameter int N_STRINGS    = 2,
    parameter int N_LEDS       = 8,
    parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      hblank_req,
    input  logic [15:0]               fifo_data,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    output logic [24*N_STRINGS-1:0]   pix_data,
    output logic                      pix_valid,
    input  logic [N_STRINGS-1:0]      pix_ready,
    input  logic [N_STRINGS-1:0]      ser_idle,
    output logic                      latch_active,
    output logic                      frame_done,
    output logic [15:0]               underflow_cnt
);

    localparam int N_WORDS = words_per_set(N_STRINGS);
    localparam int WIDX_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int PIDX_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int LCNT_W  = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    if (N_STRINGS % 2 != 0) begin : g_bad_n_strings
        $error("led_frame_sched: N_STRINGS must be even");
    end

    state_t              state;
    logic [WIDX_W-1:0]   word_cnt;
    logic [PIDX_W-1:0]   pix_idx;
    logic [LCNT_W-1:0]   latch_cnt;
    logic                hblank_flag;
    logic                pop;
    logic                transfer;
    logic                last_word;

    // The FIFO is show-ahead, so the pop has to be combinational; rst gates it so a reset never eats a word.
    assign pop        = (state == ST_LOAD) && !fifo_empty && !rst;
    assign fifo_rd_en = pop;
    assign transfer   = pix_valid && (&pix_ready);
    assign last_word  = (word_cnt == WIDX_W'(N_WORDS - 1));

    led_pixel_unpack #(
        .N_STRINGS (N_STRINGS),
        .WIDX_W    (WIDX_W)
    ) u_unpack (
        .clk      (clk),
        .rst      (rst),
        .load     (pop),
        .word_idx (word_cnt),
        .word     (fifo_data),
        .pix_data (pix_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            word_cnt      <= '0;
            pix_idx       <= '0;
            latch_cnt     <= '0;
            hblank_flag   <= 1'b0;
            pix_valid     <= 1'b0;
            latch_active  <= 1'b0;
            frame_done    <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            frame_done <= 1'b0;
            if (hblank_req) begin
                hblank_flag <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (hblank_flag) begin
                        state <= ST_DRAIN;
                    end else if (enable && !fifo_empty) begin
                        state    <= ST_LOAD;
                        word_cnt <= '0;
                    end
                end

                ST_LOAD: begin
                    if (fifo_empty) begin
                        if (underflow_cnt != 16'hFFFF) begin
                            underflow_cnt <= underflow_cnt + 16'd1;
                        end
                    end else if (last_word) begin
                        state     <= ST_SEND;
                        pix_valid <= 1'b1;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end

                ST_SEND: begin
                    if (transfer) begin
                        pix_valid <= 1'b0;
                        if (pix_idx == PIDX_W'(N_LEDS - 1)) begin
                            state   <= ST_DRAIN;
                            pix_idx <= '0;
                        end else begin
                            state    <= ST_LOAD;
                            pix_idx  <= pix_idx + 1'b1;
                            word_cnt <= '0;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (&ser_idle) begin
                        state        <= ST_LATCH;
                        latch_cnt    <= LCNT_W'(LATCH_CYCLES - 1);
                        latch_active <= 1'b1;
                    end
                end

                ST_LATCH: begin
                    // The clear here overrides a same-cycle hblank_req, so a request during the latch is absorbed.
                    if (latch_cnt == '0) begin
                        state        <= ST_IDLE;
                        latch_active <= 1'b0;
                        frame_done   <= 1'b1;
                        hblank_flag  <= 1'b0;
                    end else begin
                        latch_cnt <= latch_cnt - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
